// File: rtl/battery_monitor.sv
// battery_monitor: level counter with drain/charge prescaler, power FSM and registered level indicators
module battery_monitor #(
  parameter int MAX       = 100,
  parameter int HI_TH     = 70,
  parameter int LO_TH     = 30,
  parameter int DRAIN_DIV = 1000,
  parameter int CHG_DIV   = 500
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       LD,
  input  logic       E,
  input  logic       D,
  input  logic       F,
  input  logic       A,
  input  logic       DOCK,
  output logic       Alto,
  output logic       Medio,
  output logic       Baixo,
  output logic       MOTOR_EN,
  output logic       CHARGING,
  output logic [7:0] LEVEL
);
  localparam int PMAX = (DRAIN_DIV > CHG_DIV) ? DRAIN_DIV : CHG_DIV;
  localparam int PW   = $clog2(PMAX + 1);

  typedef enum logic [1:0] {IDLE, DRAIN, CHARGE, DEAD} state_t;

  state_t        state_q, state_d;
  logic [7:0]    level_q, level_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          alto_q, alto_d, medio_q, medio_d, baixo_q, baixo_d, motor_q, motor_d;
  logic          stay, drain_end, chg_end, counting;

  // next state by fixed priority: dock, empty battery, powered motion, otherwise idle
  always_comb begin
    state_d = DOCK ? CHARGE : (level_q == 8'd0) ? DEAD : (LD && (E | D | F | A)) ? DRAIN : IDLE;
  end

  // prescaler and level stepping; a state change discards the partial count and suppresses the step
  always_comb begin
    stay      = (state_d == state_q);
    drain_end = (presc_q == PW'(DRAIN_DIV - 1));
    chg_end   = (presc_q == PW'(CHG_DIV - 1));
    counting  = stay && (state_q == DRAIN || state_q == CHARGE);
    presc_d   = !counting ? '0 : ((state_q == DRAIN) ? drain_end : chg_end) ? '0 : presc_q + PW'(1);
    level_d   = (counting && state_q == DRAIN && drain_end && level_q != 8'd0) ? level_q - 8'd1 :
                (counting && state_q == CHARGE && chg_end && level_q < 8'(MAX)) ? level_q + 8'd1 : level_q;
    baixo_d   = (level_q != 8'd0);
    medio_d   = (level_q >= 8'(LO_TH));
    alto_d    = (level_q >= 8'(HI_TH));
    motor_d   = LD && (state_d == IDLE || state_d == DRAIN);
  end

  // state, level, prescaler and registered outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      level_q <= 8'(MAX);
      presc_q <= '0;
      alto_q  <= 1'b1;
      medio_q <= 1'b1;
      baixo_q <= 1'b1;
      motor_q <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      presc_q <= presc_d;
      alto_q  <= alto_d;
      medio_q <= medio_d;
      baixo_q <= baixo_d;
      motor_q <= motor_d;
    end
  end

  assign Alto     = alto_q;
  assign Medio    = medio_q;
  assign Baixo    = baixo_q;
  assign MOTOR_EN = motor_q;
  assign CHARGING = (state_q == CHARGE);
  assign LEVEL    = level_q;
endmodule

// File: tb/tb_battery_monitor.sv
// tb_battery_monitor: directed scenario tests for battery_monitor with small parameters
module tb_battery_monitor;
  logic CLK = 1'b0, RST_N = 1'b0, LD = 1'b0, E = 1'b0, D = 1'b0, F = 1'b0, A = 1'b0, DOCK = 1'b0;
  logic Alto, Medio, Baixo, MOTOR_EN, CHARGING;
  logic [7:0] LEVEL;
  int errors = 0;
  int checks = 0;

  battery_monitor #(.MAX(10), .HI_TH(7), .LO_TH(3), .DRAIN_DIV(4), .CHG_DIV(2)) dut (
    .CLK(CLK), .RST_N(RST_N), .LD(LD), .E(E), .D(D), .F(F), .A(A), .DOCK(DOCK),
    .Alto(Alto), .Medio(Medio), .Baixo(Baixo), .MOTOR_EN(MOTOR_EN), .CHARGING(CHARGING), .LEVEL(LEVEL)
  );

  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic test_reset;
    RST_N = 1'b0;
    LD = 1'b1;
    F = 1'b1;
    repeat (2) @(negedge CLK);
    checks++;
    if (LEVEL !== 8'd10) begin errors++; $display("FAIL reset_level got=%0d exp=10", LEVEL); end
    checks++;
    if ({Alto, Medio, Baixo} !== 3'b111) begin errors++; $display("FAIL reset_thermo got=%b exp=111", {Alto, Medio, Baixo}); end
    checks++;
    if ({MOTOR_EN, CHARGING} !== 2'b00) begin errors++; $display("FAIL reset_ctrl got=%b exp=00", {MOTOR_EN, CHARGING}); end
  endtask

  task automatic test_drain;
    RST_N = 1'b1;
    for (int i = 1; i <= 42; i++) begin
      tick();
      if (i == 1) begin
        checks++;
        if (LEVEL !== 8'd10 || MOTOR_EN !== 1'b1) begin errors++; $display("FAIL drain_start level=%0d motor=%b exp 10/1", LEVEL, MOTOR_EN); end
      end
      if (i == 4) begin
        checks++;
        if (LEVEL !== 8'd10) begin errors++; $display("FAIL drain_hold4 got=%0d exp=10", LEVEL); end
      end
      if (i == 5) begin
        checks++;
        if (LEVEL !== 8'd9) begin errors++; $display("FAIL drain_first_step got=%0d exp=9", LEVEL); end
      end
      if (i == 17) begin
        checks++;
        if (LEVEL !== 8'd6 || Alto !== 1'b1) begin errors++; $display("FAIL drain_l6 level=%0d alto=%b exp 6/1", LEVEL, Alto); end
      end
      if (i == 18) begin
        checks++;
        if ({Alto, Medio, Baixo} !== 3'b011) begin errors++; $display("FAIL drain_alto_fall got=%b exp=011", {Alto, Medio, Baixo}); end
      end
      if (i == 33) begin
        checks++;
        if (LEVEL !== 8'd2 || Medio !== 1'b1) begin errors++; $display("FAIL drain_l2 level=%0d medio=%b exp 2/1", LEVEL, Medio); end
      end
      if (i == 34) begin
        checks++;
        if (Medio !== 1'b0) begin errors++; $display("FAIL drain_medio_fall got=%b exp=0", Medio); end
      end
      if (i == 41) begin
        checks++;
        if (LEVEL !== 8'd0 || MOTOR_EN !== 1'b1 || Baixo !== 1'b1) begin errors++; $display("FAIL drain_l0 level=%0d motor=%b baixo=%b exp 0/1/1", LEVEL, MOTOR_EN, Baixo); end
      end
      if (i == 42) begin
        checks++;
        if (LEVEL !== 8'd0 || {MOTOR_EN, CHARGING} !== 2'b00 || {Alto, Medio, Baixo} !== 3'b000) begin
          errors++; $display("FAIL dead_entry level=%0d ctrl=%b thermo=%b exp 0/00/000", LEVEL, {MOTOR_EN, CHARGING}, {Alto, Medio, Baixo});
        end
      end
    end
  endtask

  task automatic test_dead;
    logic [4:0] vec [8] = '{5'b10000, 5'b11000, 5'b00110, 5'b10101, 5'b01111, 5'b11111, 5'b10010, 5'b00000};
    for (int i = 0; i < 8; i++) begin
      {LD, E, D, F, A} = vec[i];
      tick();
      checks++;
      if (LEVEL !== 8'd0 || MOTOR_EN !== 1'b0 || CHARGING !== 1'b0) begin
        errors++; $display("FAIL dead_hold vec=%b level=%0d motor=%b chg=%b exp 0/0/0", vec[i], LEVEL, MOTOR_EN, CHARGING);
      end
    end
  endtask

  task automatic test_charge;
    {LD, E, D, F, A} = 5'b00000;
    DOCK = 1'b1;
    for (int i = 1; i <= 25; i++) begin
      tick();
      if (i == 1) begin
        checks++;
        if (CHARGING !== 1'b1 || MOTOR_EN !== 1'b0 || LEVEL !== 8'd0) begin errors++; $display("FAIL chg_enter chg=%b motor=%b level=%0d exp 1/0/0", CHARGING, MOTOR_EN, LEVEL); end
      end
      if (i == 3) begin
        checks++;
        if (LEVEL !== 8'd1 || Baixo !== 1'b0) begin errors++; $display("FAIL chg_l1 level=%0d baixo=%b exp 1/0", LEVEL, Baixo); end
      end
      if (i == 4) begin
        checks++;
        if (Baixo !== 1'b1) begin errors++; $display("FAIL chg_baixo_rise got=%b exp=1", Baixo); end
      end
      if (i == 7) begin
        checks++;
        if (LEVEL !== 8'd3 || Medio !== 1'b0) begin errors++; $display("FAIL chg_l3 level=%0d medio=%b exp 3/0", LEVEL, Medio); end
      end
      if (i == 8) begin
        checks++;
        if (Medio !== 1'b1) begin errors++; $display("FAIL chg_medio_rise got=%b exp=1", Medio); end
      end
      if (i == 15) begin
        checks++;
        if (LEVEL !== 8'd7 || Alto !== 1'b0) begin errors++; $display("FAIL chg_l7 level=%0d alto=%b exp 7/0", LEVEL, Alto); end
      end
      if (i == 16) begin
        checks++;
        if (Alto !== 1'b1) begin errors++; $display("FAIL chg_alto_rise got=%b exp=1", Alto); end
      end
      if (i == 21) begin
        checks++;
        if (LEVEL !== 8'd10) begin errors++; $display("FAIL chg_full got=%0d exp=10", LEVEL); end
      end
      if (i == 25) begin
        checks++;
        if (LEVEL !== 8'd10 || CHARGING !== 1'b1 || MOTOR_EN !== 1'b0) begin errors++; $display("FAIL chg_saturate level=%0d chg=%b motor=%b exp 10/1/0", LEVEL, CHARGING, MOTOR_EN); end
      end
    end
  endtask

  task automatic test_dock_interrupt;
    DOCK = 1'b0;
    LD = 1'b1;
    F = 1'b1;
    repeat (24) tick();
    checks++;
    if (LEVEL !== 8'd5 || MOTOR_EN !== 1'b1 || CHARGING !== 1'b0) begin errors++; $display("FAIL int_pre level=%0d motor=%b chg=%b exp 5/1/0", LEVEL, MOTOR_EN, CHARGING); end
    DOCK = 1'b1;
    tick();
    checks++;
    if (LEVEL !== 8'd5 || CHARGING !== 1'b1 || MOTOR_EN !== 1'b0) begin errors++; $display("FAIL int_dock level=%0d chg=%b motor=%b exp 5/1/0", LEVEL, CHARGING, MOTOR_EN); end
    tick();
    checks++;
    if (LEVEL !== 8'd5) begin errors++; $display("FAIL int_presc_restart got=%0d exp=5", LEVEL); end
    tick();
    checks++;
    if (LEVEL !== 8'd6) begin errors++; $display("FAIL int_first_charge got=%0d exp=6", LEVEL); end
  endtask

  task automatic test_async_reset;
    DOCK = 1'b0;
    LD = 1'b1;
    F = 1'b1;
    repeat (4) tick();
    checks++;
    if (LEVEL !== 8'd6 || MOTOR_EN !== 1'b1 || Alto !== 1'b0) begin errors++; $display("FAIL rst_pre level=%0d motor=%b alto=%b exp 6/1/0", LEVEL, MOTOR_EN, Alto); end
    #2 RST_N = 1'b0;
    #1;
    checks++;
    if (LEVEL !== 8'd10 || {Alto, Medio, Baixo} !== 3'b111 || {MOTOR_EN, CHARGING} !== 2'b00) begin
      errors++; $display("FAIL rst_async level=%0d thermo=%b ctrl=%b exp 10/111/00", LEVEL, {Alto, Medio, Baixo}, {MOTOR_EN, CHARGING});
    end
    #1 RST_N = 1'b1;
    tick();
    checks++;
    if (LEVEL !== 8'd10 || MOTOR_EN !== 1'b1) begin errors++; $display("FAIL rst_release level=%0d motor=%b exp 10/1", LEVEL, MOTOR_EN); end
    repeat (3) tick();
    checks++;
    if (LEVEL !== 8'd10) begin errors++; $display("FAIL rst_presc_cleared got=%0d exp=10", LEVEL); end
    tick();
    checks++;
    if (LEVEL !== 8'd9) begin errors++; $display("FAIL rst_first_step got=%0d exp=9", LEVEL); end
  endtask

  task automatic test_ld_off;
    int bad = 0;
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
    DOCK = 1'b0;
    {LD, E, D, F, A} = 5'b01111;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (LEVEL !== 8'd10 || MOTOR_EN !== 1'b0 || CHARGING !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL ld_off bad_cycles=%0d exp=0 (level=%0d motor=%b)", bad, LEVEL, MOTOR_EN); end
    {LD, E, D, F, A} = 5'b10000;
    tick();
    checks++;
    if (MOTOR_EN !== 1'b1 || CHARGING !== 1'b0 || LEVEL !== 8'd10) begin errors++; $display("FAIL ld_on_idle motor=%b chg=%b level=%0d exp 1/0/10", MOTOR_EN, CHARGING, LEVEL); end
  endtask

  initial begin
    test_reset();
    test_drain();
    test_dead();
    test_charge();
    test_dock_interrupt();
    test_async_reset();
    test_ld_off();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/battery_monitor.md
BATTERY_MONITOR -- requirements
Module: battery_monitor

Interface
REQ-001 Parameter MAX, default 100, full-charge value of the level counter (1..255).
REQ-002 Parameter HI_TH, default 70, level at or above which Alto is asserted; the legal range is LO_TH < HI_TH <= MAX.
REQ-003 Parameter LO_TH, default 30, level at or above which Medio is asserted; the legal range is 1 < LO_TH < HI_TH.
REQ-004 Parameter DRAIN_DIV, default 1000, number of clock cycles per one-step discharge.
REQ-005 Parameter CHG_DIV, default 500, number of clock cycles per one-step charge.
REQ-006 Port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 Port RST_N, input, 1 bit: asynchronous, active-low reset.
REQ-008 Port LD, input, 1 bit: robot power switch (1 = on).
REQ-009 Ports E, D, F, A, input, 1 bit each: motion requests (left, right, forward, back).
REQ-010 Port DOCK, input, 1 bit: robot is on the charging base.
REQ-011 Ports Alto, Medio, Baixo, output, 1 bit each: thermometer-coded battery level for the LED/display stage.
REQ-012 Port MOTOR_EN, output, 1 bit: motion is permitted.
REQ-013 Port CHARGING, output, 1 bit: the block is in the CHARGE state.
REQ-014 Port LEVEL, output, 8 bits: current level counter value.

Function
REQ-015 Level counter: 8 bits, saturating at 0 and at MAX, never wraps.
REQ-016 FSM states:
- IDLE
- DRAIN
- CHARGE
- DEAD
REQ-017 Transition priority, evaluated every cycle:
- DOCK=1 -> CHARGE (highest priority, from any state);
- else level==0 -> DEAD;
- else LD=1 and (E|D|F|A)=1 -> DRAIN;
- else -> IDLE.
REQ-018 DEAD is left only via DOCK=1; neither LD nor motion exits it.
REQ-019 Prescaler counter: counts only in DRAIN (modulus DRAIN_DIV) and CHARGE (modulus CHG_DIV).
REQ-020 Prescaler clears to 0 on any state change, and holds at 0 in IDLE and DEAD.
REQ-021 In DRAIN, when the prescaler equals DRAIN_DIV-1: level decrements by 1 (if >0) and the prescaler returns to 0 in the same cycle.
REQ-022 In CHARGE, when the prescaler equals CHG_DIV-1: level increments by 1 (if <MAX) and the prescaler returns to 0.
REQ-023 A level reaching 0 in DRAIN moves the FSM to DEAD on the next clock edge.
REQ-024 Thermometer outputs are registered, updating one cycle after LEVEL changes:
- Baixo = (level >= 1)
- Medio = (level >= LO_TH)
- Alto = (level >= HI_TH)
REQ-025 The combination Alto=1 with Medio=0 shall never be produced.
REQ-026 MOTOR_EN = 1 only in IDLE or DRAIN while LD=1; it is 0 in CHARGE, in DEAD, and when LD=0.
REQ-027 CHARGING = 1 exactly while the state is CHARGE.
REQ-028 Motion inputs are ignored while LD=0: the state stays IDLE and no drain occurs.
REQ-029 When DOCK and motion are asserted together, CHARGE wins and no drain step occurs in that cycle.
REQ-030 In CHARGE at level MAX: the state remains CHARGE, the level holds, and the prescaler keeps running with no effect.

Reset
REQ-031 RST_N=0 asynchronously forces:
- state = IDLE
- level = MAX
- prescaler = 0
- Alto = Medio = Baixo = 1
- MOTOR_EN = 0
- CHARGING = 0
REQ-032 Asserting reset mid-drain or mid-charge discards the partial prescaler count.
REQ-033 After release, the first rising edge evaluates REQ-017 normally.

Verification (MAX=10, HI_TH=7, LO_TH=3, DRAIN_DIV=4, CHG_DIV=2)
REQ-034 Reset, then LD=1, F=1 held for 16 cycles:
- LEVEL goes 10->6, one step every 4 cycles;
- Alto falls one cycle after LEVEL=6;
- Medio=1 and Baixo=1 remain.
REQ-035 Continue draining to 0:
- state DEAD, MOTOR_EN=0, Baixo=Medio=Alto=0;
- LD toggles and motion changes leave DEAD and LEVEL=0 unchanged.
REQ-036 From DEAD, DOCK=1 for 20 cycles:
- CHARGING=1, LEVEL climbs 0->10 and saturates at 10;
- Baixo rises at LEVEL=1, Medio at 3, Alto at 7.
REQ-037 LEVEL=5 in DRAIN, then DOCK=1 with F=1 still held:
- immediate CHARGE, MOTOR_EN=0, no decrement;
- the prescaler restarts at 0.
REQ-038 In DRAIN with the prescaler at 3, pulse RST_N low for a fraction of a cycle:
- outputs take reset values without waiting for a clock edge;
- LEVEL=10 and the prescaler=0 after release.
REQ-039 With LD=0 and E=D=F=A=1 for 50 cycles:
- LEVEL stays 10, state IDLE, MOTOR_EN=0.
